// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: sequencer state encodings and the reset vector.
// Imported by the PC controller, brancher and decoder.
package mips_cpu_pkg;

    // EXEC1 must stay 4'b0010: brancher decodes that exact value.
    typedef enum logic [3:0] {
        FETCH  = 4'b0000,
        DECODE = 4'b0001,
        EXEC1  = 4'b0010,
        EXEC2  = 4'b0011,
        HALT   = 4'b1111
    } state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/mips_cpu_pc_ctrl_if.sv
// Instruction-fetch bus between the PC controller (master) and instruction memory (slave).
interface mips_cpu_pc_ctrl_if;

    logic [31:0] pc;
    logic        instr_read;
    logic        instr_waitrequest;

    modport master (output pc, output instr_read, input instr_waitrequest);
    modport slave  (input pc, input instr_read, output instr_waitrequest);

endinterface

// File: rtl/mips_cpu_pc_ctrl.sv
// Multicycle sequencer and PC controller with one-instruction branch delay slots.
// Optional MIPS_CPU_ALIGN_CHECK_EN traps misaligned redirect targets via the fault output.
module mips_cpu_pc_ctrl
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    mips_cpu_pc_ctrl_if.master        fetch,
    output logic [3:0]                state,
    output logic                      active,
    input  logic                      need_exec2,
    input  logic                      exec2_busy,
    input  logic                      JumpIN,
    input  logic                      Jump_EN,
    input  logic [31:0]               jump_target
`ifdef MIPS_CPU_ALIGN_CHECK_EN
   ,output logic                      fault
`endif
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_active;
    logic        r_redirect;
    logic [31:0] r_tgt;
    logic        r_taken_now;
    logic [31:0] r_tgt_now;

    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic        w_redirect_next;
    logic [31:0] w_tgt_next;
    logic        w_taken_now;
    logic [31:0] w_tgt_now;
    logic        w_commit;
    logic [31:0] w_pc_target;
    logic        w_trap;
    logic        w_fault_next;
    logic        r_fault;

    // A commit straight out of EXEC1 must see this cycle's brancher result, not the stale register.
    assign w_taken_now = (r_state == EXEC1) ? (Jump_EN & JumpIN) : r_taken_now;
    assign w_tgt_now   = (r_state == EXEC1) ? jump_target : r_tgt_now;
    assign w_commit    = ((r_state == EXEC1) && !need_exec2) ||
                         ((r_state == EXEC2) && !exec2_busy);
    assign w_pc_target = r_redirect ? r_tgt : r_pc + 32'd4;

`ifdef MIPS_CPU_ALIGN_CHECK_EN
    assign w_trap = r_redirect && (r_tgt[1:0] != 2'b00);
    assign fault  = r_fault;
`else
    assign w_trap = 1'b0;
`endif

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_redirect_next = r_redirect;
        w_tgt_next      = r_tgt;
        w_fault_next    = r_fault;

        case (r_state)
            FETCH:   if (!fetch.instr_waitrequest) w_state_next = DECODE;
            DECODE:  w_state_next = EXEC1;
            EXEC1:   if (need_exec2) w_state_next = EXEC2;
            EXEC2:   w_state_next = EXEC2;
            HALT:    w_state_next = HALT;
            default: w_state_next = FETCH;
        endcase

        if (w_commit) begin
            if (w_trap) begin
                w_fault_next = 1'b1;
                w_state_next = HALT;
            end else begin
                w_pc_next       = w_pc_target;
                w_redirect_next = w_taken_now;
                w_tgt_next      = w_tgt_now;
                w_state_next    = (w_pc_target == 32'h0) ? HALT : FETCH;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH;
            r_pc        <= RESET_VECTOR;
            r_active    <= 1'b1;
            r_redirect  <= 1'b0;
            r_tgt       <= 32'h0;
            r_taken_now <= 1'b0;
            r_tgt_now   <= 32'h0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_active   <= (w_state_next != HALT);
            r_redirect <= w_redirect_next;
            r_tgt      <= w_tgt_next;
            if (r_state == EXEC1) begin
                r_taken_now <= Jump_EN & JumpIN;
                r_tgt_now   <= jump_target;
            end
        end
    end

`ifdef MIPS_CPU_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) r_fault <= 1'b0;
        else       r_fault <= w_fault_next;
    end
`else
    assign r_fault = 1'b0;
`endif

    assign state            = r_state;
    assign active           = r_active;
    assign fetch.pc         = r_pc;
    assign fetch.instr_read = (r_state == FETCH) && !reset;

endmodule

// File: tb/tb_mips_cpu_pc_ctrl.sv
// Self-checking bench for mips_cpu_pc_ctrl: directed scenarios plus randomized instruction
// streams compared against an instruction-level model of PC and delay-slot behaviour.
module tb_mips_cpu_pc_ctrl;
    import mips_cpu_pkg::*;

    localparam logic [31:0] RV = 32'hBFC0_0000;
`ifdef MIPS_CPU_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic        active;
    logic        need_exec2;
    logic        exec2_busy;
    logic        JumpIN;
    logic        Jump_EN;
    logic [31:0] jump_target;
`ifdef MIPS_CPU_ALIGN_CHECK_EN
    logic        fault;
`endif

    mips_cpu_pc_ctrl_if bus ();

    mips_cpu_pc_ctrl #(.RESET_VECTOR(RV)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch       (bus),
        .state       (state),
        .active      (active),
        .need_exec2  (need_exec2),
        .exec2_busy  (exec2_busy),
        .JumpIN      (JumpIN),
        .Jump_EN     (Jump_EN),
        .jump_target (jump_target)
`ifdef MIPS_CPU_ALIGN_CHECK_EN
       ,.fault       (fault)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instruction-level reference: current PC, pending redirect, halt/fault status.
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_tgt;
    bit          m_halt;
    bit          m_fault;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic noise();
        Jump_EN               = 1'($urandom);
        JumpIN                = 1'($urandom);
        jump_target           = $urandom;
        need_exec2            = 1'($urandom);
        exec2_busy            = 1'($urandom);
        bus.instr_waitrequest = 1'($urandom);
    endtask

    task automatic model_reset();
        m_pc = RV; m_pend = 0; m_pend_tgt = 32'h0; m_halt = 0; m_fault = 0;
    endtask

    // Architectural effect of committing one instruction.
    task automatic model_commit(input bit taken, input logic [31:0] tgt);
        logic [31:0] nxt;
        if (m_pend && ALIGN && (m_pend_tgt[1:0] != 2'b00)) begin
            m_fault = 1;
            m_halt  = 1;
            return;
        end
        nxt        = m_pend ? m_pend_tgt : m_pc + 32'd4;
        m_pend     = taken;
        m_pend_tgt = tgt;
        m_pc       = nxt;
        if (nxt == 32'h0) m_halt = 1;
    endtask

    task automatic do_reset();
        noise();
        reset = 1'b1;
        cyc();
        cyc();
        check("rst_state", 32'(state), 32'(FETCH));
        check("rst_pc", bus.pc, RV);
        check("rst_active", 32'(active), 32'd1);
        check("rst_instr_read_gated", 32'(bus.instr_read), 32'd0);
`ifdef MIPS_CPU_ALIGN_CHECK_EN
        check("rst_fault", 32'(fault), 32'd0);
`endif
        reset = 1'b0;
        #1;
        model_reset();
    endtask

    // Runs one instruction: nwait fetch stalls, optional EXEC2 with nbusy stalls.
    task automatic run_instr(input int nwait, input bit ex2, input int nbusy,
                             input bit jen, input bit jin, input logic [31:0] tgt,
                             input bit rst_ex2);
        for (int i = 0; i <= nwait; i++) begin
            check("fetch_state", 32'(state), 32'(FETCH));
            check("fetch_pc", bus.pc, m_pc);
            check("fetch_rd", 32'(bus.instr_read), 32'd1);
            noise();
            bus.instr_waitrequest = (i < nwait);
            cyc();
        end
        check("decode_state", 32'(state), 32'(DECODE));
        check("decode_pc", bus.pc, m_pc);
        noise();
        cyc();
        check("exec1_state", 32'(state), 32'(EXEC1));
        check("exec1_pc", bus.pc, m_pc);
        noise();
        Jump_EN     = jen;
        JumpIN      = jin;
        jump_target = tgt;
        need_exec2  = ex2;
        cyc();
        if (ex2) begin
            for (int i = 0; i <= nbusy; i++) begin
                check("exec2_state", 32'(state), 32'(EXEC2));
                check("exec2_pc", bus.pc, m_pc);
                noise();
                if (rst_ex2 && i == 1) begin
                    reset = 1'b1;
                    cyc();
                    check("rst_ex2_state", 32'(state), 32'(FETCH));
                    check("rst_ex2_pc", bus.pc, RV);
                    check("rst_ex2_rd_gated", 32'(bus.instr_read), 32'd0);
                    reset = 1'b0;
                    #1;
                    model_reset();
                    return;
                end
                exec2_busy = (i < nbusy);
                cyc();
            end
        end
        model_commit(jen & jin, tgt);
        if (m_halt) begin
            check("halt_state", 32'(state), 32'(HALT));
            check("halt_active", 32'(active), 32'd0);
        end
    endtask

    task automatic plain(input int n);
        for (int k = 0; k < n; k++) run_instr(0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        reset = 1'b1;
        noise();
        model_reset();

        // Zero-wait sequential stream.
        do_reset();
        plain(3);
        check("seq_pc", bus.pc, RV + 32'd12);

        // Fetch stalled two cycles.
        run_instr(2, 0, 0, 0, 0, 32'h0, 0);

        // Taken branch with delay slot.
        do_reset();
        run_instr(0, 0, 0, 1, 1, 32'hBFC0_0100, 0);
        check("delay_slot_pc", bus.pc, RV + 32'd4);
        plain(1);
        check("branch_tgt_pc", bus.pc, 32'hBFC0_0100);

        // Branch inside a delay slot.
        run_instr(0, 0, 0, 1, 1, 32'hBFC0_0200, 0);
        run_instr(0, 0, 0, 1, 1, 32'hBFC0_0300, 0);
        check("nested_first_tgt", bus.pc, 32'hBFC0_0200);
        plain(1);
        check("nested_second_tgt", bus.pc, 32'hBFC0_0300);

        // EXEC2 busy three cycles.
        run_instr(0, 1, 3, 0, 0, 32'h0, 0);
        check("exec2_pc_inc", bus.pc, 32'hBFC0_0304);

        // Reset during EXEC2 clears a pending redirect.
        run_instr(0, 0, 0, 1, 1, 32'hBFC0_0800, 0);
        run_instr(0, 1, 3, 0, 0, 32'h0, 1);
        plain(2);
        check("rst_ex2_no_redirect", bus.pc, RV + 32'd8);

        // Misaligned redirect target.
        do_reset();
        run_instr(0, 0, 0, 1, 1, 32'hBFC0_0102, 0);
        plain(1);
`ifdef MIPS_CPU_ALIGN_CHECK_EN
        check("misalign_fault", 32'(fault), 32'd1);
        check("misalign_halt", 32'(state), 32'(HALT));
        check("misalign_pc", bus.pc, 32'hBFC0_0004);
`else
        check("misalign_pc", bus.pc, 32'hBFC0_0102);
`endif

        // Randomized instruction streams.
        do_reset();
        for (int k = 0; k < 200; k++) begin
            logic [31:0] t;
            t = 32'h0040_0000 | ($urandom_range(0, 1023) << 2);
            run_instr($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom), t, 0);
        end

        // Jump to zero halts after the delay slot.
        do_reset();
        plain(4);
        check("pre_halt_pc", bus.pc, 32'hBFC0_0010);
        run_instr(0, 0, 0, 1, 1, 32'h0, 0);
        check("halt_delay_pc", bus.pc, 32'hBFC0_0014);
        plain(1);
        for (int i = 0; i < 12; i++) begin
            check("halted_state", 32'(state), 32'(HALT));
            check("halted_active", 32'(active), 32'd0);
            check("halted_rd", 32'(bus.instr_read), 32'd0);
            check("halted_pc", bus.pc, 32'h0);
            noise();
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
